// File: rtl/cu_multicycle.sv
// -----------------------------------------------------------------------------
// cu_multicycle
//
// Multi-cycle control unit. Accepts one instruction at a time over a
// valid/ready handshake. It decodes ALU, LOAD and STORE instructions and
// drives operands, offset, opcode and mux selects to the datapath. It waits
// on the data memory and writes results back into an internal register file.
//
// Instruction fields, MSB to LSB:
//   type[2] rd[REG_BITS] rs1[REG_BITS] rs2[REG_BITS] offset[DATA_WIDTH] opcode[4]
//   type: 00 NOP, 01 ALU, 10 LOAD, 11 STORE
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous active-low reset
//   instr        instruction word, sampled on accept
//   instr_valid  instruction present
//   instr_ready  high when the unit can accept an instruction (IDLE)
//   result2      write-back data (ALU result or memory read data)
//   mem_ready    data memory has completed its access (used in MEM_ACCESS only)
//   operand1     reg[rs1]
//   operand2     reg[rs2] for ALU, reg[rd] for LOAD/STORE
//   offset       instruction offset field
//   opcode       ALU opcode
//   sel1, sel3   datapath mux selects
//   w_r          data-memory write strobe (STORE, EXECUTE cycle only)
//   busy         state is not IDLE
//   done         one-cycle pulse on instruction retirement
//   reg_file     flattened register file, reg[0] in the LSBs
//
// Configuration macro:
//   CU_ZERO_REG_EN  when defined, reg[0] is hardwired to zero and write-backs
//                   to rd=0 are discarded (timing and done are unchanged).
// -----------------------------------------------------------------------------
module cu_multicycle #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_BITS   = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [2+3*REG_BITS+DATA_WIDTH+4-1:0]    instr,
    input  logic                                    instr_valid,
    output logic                                    instr_ready,
    input  logic [DATA_WIDTH-1:0]                   result2,
    input  logic                                    mem_ready,
    output logic [DATA_WIDTH-1:0]                   operand1,
    output logic [DATA_WIDTH-1:0]                   operand2,
    output logic [DATA_WIDTH-1:0]                   offset,
    output logic [3:0]                              opcode,
    output logic                                    sel1,
    output logic                                    sel3,
    output logic                                    w_r,
    output logic                                    busy,
    output logic                                    done,
    output logic [(2**REG_BITS)*DATA_WIDTH-1:0]     reg_file
);

    localparam int INSTR_WIDTH = 2 + 3*REG_BITS + DATA_WIDTH + 4;
    localparam int REG_COUNT   = 2**REG_BITS;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXECUTE,
        MEM_ACCESS,
        WRITE_BACK
    } state_t;

    typedef enum logic [1:0] {
        T_NOP   = 2'b00,
        T_ALU   = 2'b01,
        T_LOAD  = 2'b10,
        T_STORE = 2'b11
    } itype_t;

    state_t                  state, state_next;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic [DATA_WIDTH-1:0]   regs [REG_COUNT];

    itype_t                  itype;
    itype_t                  in_type;
    logic [REG_BITS-1:0]     rd, rs1, rs2;
    logic                    accept;
    logic                    done_next;
    logic                    wb_en;

    // Field decode of the latched instruction
    assign itype = itype_t'(instr_q[INSTR_WIDTH-1 -: 2]);
    assign rd    = instr_q[INSTR_WIDTH-3 -: REG_BITS];
    assign rs1   = instr_q[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
    assign rs2   = instr_q[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];

    // The IDLE decision (NOP or not) is made from the incoming word, since
    // instr_q only captures it on the accepting edge.
    assign in_type = itype_t'(instr[INSTR_WIDTH-1 -: 2]);

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = instr_valid && (state == IDLE);
    assign w_r         = (state == EXECUTE) && (itype == T_STORE);
    assign wb_en       = (state == WRITE_BACK);

    // Next-state and retirement logic
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_type == T_NOP) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = DECODE;
                    end
                end
            end
            DECODE: begin
                state_next = EXECUTE;
            end
            EXECUTE: begin
                state_next = (itype == T_ALU) ? WRITE_BACK : MEM_ACCESS;
            end
            MEM_ACCESS: begin
                if (mem_ready) begin
                    if (itype == T_LOAD) begin
                        state_next = WRITE_BACK;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            WRITE_BACK: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
        end else if (accept) begin
            instr_q <= instr;
        end
    end

    // Datapath controls are captured on the edge leaving DECODE and held
    // until the next instruction reaches EXECUTE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            operand1 <= '0;
            operand2 <= '0;
            offset   <= '0;
            opcode   <= 4'hF;
            sel1     <= 1'b0;
            sel3     <= 1'b0;
        end else if (state == DECODE) begin
            operand1 <= regs[rs1];
            operand2 <= (itype == T_ALU) ? regs[rs2] : regs[rd];
            offset   <= instr_q[4 +: DATA_WIDTH];
            opcode   <= instr_q[3:0];
            sel1     <= (itype == T_ALU);
            sel3     <= (itype != T_ALU);
        end
    end

    // Register file: reg[i] resets to i (reg[0] therefore resets to zero in
    // both build variants).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= DATA_WIDTH'(i);
            end
        end else if (wb_en) begin
`ifdef CU_ZERO_REG_EN
            if (rd != '0) begin
                regs[rd] <= result2;
            end
`else
            regs[rd] <= result2;
`endif
        end
    end

    always_comb begin
        reg_file = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            reg_file[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule
